// File: rtl/pc_sequencer.sv
// Program-counter sequencer: clear/load/increment, relative branch, call/return
// with a hardware return-address stack. Optional sticky wrap flag via PC_WRAP_FLAG_EN.
module pc_sequencer #(
    parameter int                ADDR_W      = 6,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              stall,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] data_in_pc,
    input  logic              inc_pc,
    input  logic              branch_rel,
    input  logic [ADDR_W-1:0] rel_offset,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] out_pc,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
`ifdef PC_WRAP_FLAG_EN
    ,
    output logic              pc_wrap
`endif
);

    localparam int              SP_W   = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    // Sized to the full pointer range so sp indexes it without width juggling.
    logic [ADDR_W-1:0] stack_mem [0:(1 << SP_W) - 1];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
    logic              push;
    logic              is_empty, is_full;
    logic [ADDR_W:0]   inc_sum, br_sum;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_MAX);

    // One extra bit catches carry out of ADDR_W (inc) and carry/borrow (branch).
    assign inc_sum = {1'b0, pc_q} + (ADDR_W + 1)'(1);
    assign br_sum  = {1'b0, pc_q} + {rel_offset[ADDR_W-1], rel_offset};

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= RESET_VEC;
            sp_q   <= '0;
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            err_q  <= err_d;
            wrap_q <= wrap_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push)
            stack_mem[sp_q] <= pc_q + ADDR_W'(1);
    end

    // Strict priority: clear > stall > call > ret > load_pc > branch_rel > inc_pc.
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        err_d  = err_q;
        wrap_d = wrap_q;
        push   = 1'b0;
        if (clear) begin
            pc_d   = RESET_VEC;
            sp_d   = '0;
            wrap_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (call) begin
            if (is_full) begin
                err_d = 1'b1;
            end else begin
                push = 1'b1;
                sp_d = sp_q + SP_W'(1);
                pc_d = data_in_pc;
            end
        end else if (ret) begin
            if (is_empty) begin
                err_d = 1'b1;
            end else begin
                sp_d = sp_q - SP_W'(1);
                pc_d = stack_mem[sp_q - SP_W'(1)];
            end
        end else if (load_pc) begin
            pc_d = data_in_pc;
        end else if (branch_rel) begin
            pc_d = br_sum[ADDR_W-1:0];
            if (br_sum[ADDR_W])
                wrap_d = 1'b1;
        end else if (inc_pc) begin
            pc_d = inc_sum[ADDR_W-1:0];
            if (inc_sum[ADDR_W])
                wrap_d = 1'b1;
        end
    end

    always_comb begin
        out_pc      = pc_q;
        stack_empty = is_empty;
        stack_full  = is_full;
        stack_err   = err_q;
`ifdef PC_WRAP_FLAG_EN
        pc_wrap     = wrap_q;
`endif
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step pushes its expected
// {pc, empty, full, err} and checks it one clock later.
module tb_pc_sequencer;

    localparam int ADDR_W = 6;
    localparam int SW     = ADDR_W + 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              stall = 1'b0;
    logic              load_pc = 1'b0;
    logic [ADDR_W-1:0] data_in_pc = '0;
    logic              inc_pc = 1'b0;
    logic              branch_rel = 1'b0;
    logic [ADDR_W-1:0] rel_offset = '0;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic [ADDR_W-1:0] out_pc;
    logic              stack_empty;
    logic              stack_full;
    logic              stack_err;
`ifdef PC_WRAP_FLAG_EN
    logic              pc_wrap;
`endif

    logic [SW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(4), .RESET_VEC('0)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .stall       (stall),
        .load_pc     (load_pc),
        .data_in_pc  (data_in_pc),
        .inc_pc      (inc_pc),
        .branch_rel  (branch_rel),
        .rel_offset  (rel_offset),
        .call        (call),
        .ret         (ret),
        .out_pc      (out_pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
`ifdef PC_WRAP_FLAG_EN
        ,
        .pc_wrap     (pc_wrap)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag);
        logic [SW-1:0] got;
        logic [SW-1:0] exp;
        got = {out_pc, stack_empty, stack_full, stack_err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: no expected entry queued", tag);
            return;
        end
        exp = exp_q.pop_front();
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got pc=%0d empty=%0b full=%0b err=%0b, expected pc=%0d empty=%0b full=%0b err=%0b",
                   tag, got[SW-1:3], got[2], got[1], got[0], exp[SW-1:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Strobes are set by the caller before this; they are released after the edge.
    task automatic step(input string tag, input logic [ADDR_W-1:0] pc,
                        input logic e, input logic f, input logic err);
        exp_q.push_back({pc, e, f, err});
        @(posedge clock);
        #1;
        check(tag);
        {reset, clear, stall, load_pc, inc_pc, branch_rel, call, ret} = '0;
    endtask

`ifdef PC_WRAP_FLAG_EN
    task automatic check_wrap(input string tag, input logic exp);
        checks++;
        assert (pc_wrap === exp) else begin
            errors++;
            $error("FAIL %s: got pc_wrap=%0b, expected %0b", tag, pc_wrap, exp);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;                                    step("reset", 0, 1, 0, 0);
        inc_pc = 1'b1;                                   step("inc1", 1, 1, 0, 0);
        inc_pc = 1'b1;                                   step("inc2", 2, 1, 0, 0);
        inc_pc = 1'b1;                                   step("inc3", 3, 1, 0, 0);
        load_pc = 1'b1; data_in_pc = 6'd63;              step("load63", 63, 1, 0, 0);
        inc_pc = 1'b1;                                   step("inc_wrap", 0, 1, 0, 0);

        load_pc = 1'b1; data_in_pc = 6'd10;              step("load10", 10, 1, 0, 0);
        branch_rel = 1'b1; rel_offset = 6'h3D;           step("br_m3", 7, 1, 0, 0);
        branch_rel = 1'b1; rel_offset = 6'd5;            step("br_p5", 12, 1, 0, 0);
        branch_rel = 1'b1; rel_offset = 6'd0;            step("br_0", 12, 1, 0, 0);

`ifdef PC_WRAP_FLAG_EN
        clear = 1'b1;                                    step("wrap_clr", 0, 1, 0, 0);
        check_wrap("wrap_cleared", 1'b0);
        load_pc = 1'b1; data_in_pc = 6'd2;               step("wrap_load2", 2, 1, 0, 0);
        check_wrap("wrap_not_by_load", 1'b0);
        branch_rel = 1'b1; rel_offset = 6'h3D;           step("wrap_br", 63, 1, 0, 0);
        check_wrap("wrap_set", 1'b1);
`endif

        load_pc = 1'b1; data_in_pc = 6'd5;               step("load5", 5, 1, 0, 0);
        call = 1'b1; data_in_pc = 6'd20;                 step("call20", 20, 0, 0, 0);
        call = 1'b1; data_in_pc = 6'd40;                 step("call40", 40, 0, 0, 0);
        ret = 1'b1;                                      step("ret21", 21, 0, 0, 0);
        ret = 1'b1;                                      step("ret6", 6, 1, 0, 0);

        call = 1'b1; data_in_pc = 6'd1;                  step("fill1", 1, 0, 0, 0);
        call = 1'b1; data_in_pc = 6'd2;                  step("fill2", 2, 0, 0, 0);
        call = 1'b1; data_in_pc = 6'd3;                  step("fill3", 3, 0, 0, 0);
        call = 1'b1; data_in_pc = 6'd4;                  step("fill4", 4, 0, 1, 0);
        call = 1'b1; data_in_pc = 6'd50;                 step("overflow", 4, 0, 1, 1);
        ret = 1'b1;                                      step("drain1", 4, 0, 0, 1);
        ret = 1'b1;                                      step("drain2", 3, 0, 0, 1);
        ret = 1'b1;                                      step("drain3", 2, 0, 0, 1);
        ret = 1'b1;                                      step("drain4", 7, 1, 0, 1);
        ret = 1'b1;                                      step("underflow", 7, 1, 0, 1);

        stall = 1'b1; inc_pc = 1'b1; call = 1'b1; data_in_pc = 6'd9;
                                                         step("stall", 7, 1, 0, 1);
        call = 1'b1; ret = 1'b1; load_pc = 1'b1; data_in_pc = 6'd33;
                                                         step("call_wins", 33, 0, 0, 1);
        call = 1'b1; data_in_pc = 6'd44;                 step("call44", 44, 0, 0, 1);
        ret = 1'b1;                                      step("ret34", 34, 0, 0, 1);
        call = 1'b1; data_in_pc = 6'd44;                 step("call44b", 44, 0, 0, 1);
        clear = 1'b1; call = 1'b1; data_in_pc = 6'd55;   step("clear_call", 0, 1, 0, 1);

        reset = 1'b1;                                    step("reset2", 0, 1, 0, 0);
        load_pc = 1'b1; data_in_pc = 6'd30;              step("load30", 30, 1, 0, 0);
        reset = 1'b1; call = 1'b1; data_in_pc = 6'd12;   step("reset_call", 0, 1, 0, 0);
        ret = 1'b1;                                      step("ret_after_reset", 0, 1, 0, 1);

        load_pc = 1'b1; branch_rel = 1'b1; inc_pc = 1'b1; data_in_pc = 6'd9; rel_offset = 6'd3;
                                                         step("load_wins", 9, 1, 0, 1);
        branch_rel = 1'b1; inc_pc = 1'b1; rel_offset = 6'd2;
                                                         step("branch_wins", 11, 1, 0, 1);
        call = 1'b1; data_in_pc = 6'd62;                 step("call62", 62, 0, 0, 1);
        ret = 1'b1;                                      step("ret12", 12, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the run so a stuck clock or step can never hang the simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the adding-machine control path.
- Keeps the existing clear/load/increment behaviour and adds:
  - PC-relative branch;
  - call/return with an internal hardware return-address stack;
  - stall;
  - stack status and error reporting.
- Sits between the instruction decoder (control strobes) and instruction memory (out_pc drives the fetch address).

Parameters:
- ADDR_W, 6, PC and address width in bits (≥2)
- STACK_DEPTH, 4, return-address stack entries (≥1)
- RESET_VEC, 0, PC value after reset/clear (ADDR_W bits)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clock clock
- clear  in  1  synchronous PC clear to RESET_VEC
- stall  in  1  hold all state this cycle
- load_pc  in  1  absolute jump to data_in_pc
- data_in_pc  in  ADDR_W  jump/call target
- inc_pc  in  1  advance PC by 1
- branch_rel  in  1  relative branch
- rel_offset  in  ADDR_W  signed two's-complement branch offset
- call  in  1  push return address, jump to data_in_pc
- ret  in  1  pop return address into PC
- out_pc  out  ADDR_W  current program counter
- stack_empty  out  1  stack holds 0 entries
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- All outputs registered or derived from registers. No combinational path from inputs to outputs.
- Reset (synchronous, highest priority):
  - out_pc=RESET_VEC, stack pointer=0, stack_err=0.
  - stack_empty=1, stack_full=0.
  - Stack contents don't-care.
  - Reset asserted mid call/ret discards that operation.
- Per-cycle priority (exactly one action taken per cycle):
  - reset > clear > stall > call > ret > load_pc > branch_rel > inc_pc > hold.
- clear:
  - out_pc=RESET_VEC; stack pointer=0.
  - stack_err unchanged.
  - Ignores every lower-priority input.
- stall: out_pc, stack and stack_err all hold, regardless of lower-priority strobes.
- call:
  - Not full: stack[sp]=out_pc+1 (mod 2^ADDR_W), sp=sp+1, out_pc=data_in_pc.
  - Full: no push, out_pc unchanged, stack_err=1.
- ret:
  - Not empty: sp=sp-1, out_pc=stack[sp-1].
  - Empty: out_pc unchanged, stack_err=1.
- load_pc: out_pc=data_in_pc.
- branch_rel:
  - out_pc=out_pc+sign-extended rel_offset, truncated to ADDR_W (mod 2^ADDR_W wrap).
  - rel_offset=0 re-executes the same address.
- inc_pc:
  - out_pc=out_pc+1.
  - Wraps from 2^ADDR_W-1 to 0.
- Strobe conflicts: call and ret together resolve as call only. All conflicts resolve purely by priority. No error is raised for conflicts.
- Stack status:
  - stack_empty=(sp==0); stack_full=(sp==STACK_DEPTH).
  - Both update the cycle after the push/pop edge, i.e. they reflect the registered sp.
- Latency: every action is visible on out_pc one clock after the strobe is sampled.
- stack_err is cleared only by reset.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- Defined:
  - Adds output pc_wrap (1 bit, reset 0), sticky.
  - Set when inc_pc or branch_rel produces an arithmetic carry/borrow out of ADDR_W bits. Example: 63+1 with ADDR_W=6, or 2+(-3).
  - Cleared by reset or clear.
  - Not set by load_pc, call or ret.
- Undefined:
  - Port and logic absent.
  - Wrap behaviour of out_pc is otherwise identical.

Test Plan:
- Reset with defaults → out_pc=0, stack_empty=1, stack_full=0, stack_err=0. Then 3 cycles inc_pc → out_pc 1,2,3. load_pc with data_in_pc=63, then inc_pc → out_pc=63, then 0.
- out_pc=10, branch_rel with rel_offset=6'h3D (−3) → out_pc=7. Then rel_offset=5 → out_pc=12. With PC_WRAP_FLAG_EN, out_pc=2 and rel_offset=−3 → out_pc=63, pc_wrap=1.
- Nested calls:
  - From out_pc=5, call to 20 → out_pc=20, stack=[6].
  - Then call to 40 → out_pc=40, stack=[6,21].
  - ret → out_pc=21; ret → out_pc=6, stack_empty=1.
- Fill the stack with 4 calls → stack_full=1. A 5th call → out_pc unchanged, stack_err=1. Drain with 4 rets; a 5th ret → out_pc unchanged, stack_err stays 1.
- Priority checks:
  - stall with inc_pc+call → nothing changes.
  - call+ret+load_pc together → call only.
  - clear+call with 2 entries stacked → out_pc=RESET_VEC, stack_empty=1, stack_err unchanged.
- Reset asserted in the same cycle as call while out_pc=30 → out_pc=0, stack_empty=1, no push recorded (a subsequent ret sets stack_err).
